// File: rtl/storage_pkg.sv
// Shared encodings and request payload for the storage responder.
package storage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  // Captured request; the byte index is held separately since its width is per-instance
  typedef struct packed {
    port_e              port;
    logic [1:0]         size;
    logic               is_load;
    logic               uns;
    logic [DATA_W-1:0]  wdata;
  } req_t;

endpackage

// File: rtl/storage_extend.sv
// Combinational byte/half/word select with sign or zero extension for loads.
module storage_extend
  import storage_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] ext_c
);

  // Select the low bytes of the little-endian word and extend them
  always_comb begin
    ext_c = '0;
    case (size)
      SZ_BYTE: ext_c = {{24{word[7] & ~uns}}, word[7:0]};
      SZ_HALF: ext_c = {{16{word[15] & ~uns}}, word[15:0]};
      SZ_WORD: ext_c = word;
      default: ext_c = '0;
    endcase
  end

endmodule

// File: rtl/storage_mgmt_responder.sv
// Single-outstanding, fixed-latency responder serving fetch reads and
// exec loads/stores from one byte-addressed array.
module storage_mgmt_responder
  import storage_pkg::*;
#(
  parameter int unsigned MEM_SIZE    = 4096,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_read_en,
  input  logic [ADDR_W-1:0] fetch_read_addr,
  output logic [31:0]       fetch_read_data,
  output logic              fetch_read_fin,
  input  logic              data_en,
  input  logic              data_is_load,
  input  logic [1:0]        data_size,
  input  logic              data_unsigned,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_fin,
  output logic              data_err,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(MEM_SIZE);

  logic [7:0] mem [MEM_SIZE];

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  req_t              req, req_n;
  logic [IDX_W-1:0]  idx, idx_n;

  logic              fetch_fin_n, data_fin_n, data_err_n, busy_n;
  logic [31:0]       fetch_data_n, data_rdata_n;

  logic [IDX_W-1:0]  rd_idx1, rd_idx2, rd_idx3;
  logic [IDX_W-1:0]  wr_idx1, wr_idx2, wr_idx3;
  logic [31:0]       rd_word_c, ext_c;
  logic              unused_addr_hi;

  // Only the low index bits address the array; the rest wrap away
  assign unused_addr_hi = ^{fetch_read_addr[ADDR_W-1:IDX_W], data_addr[ADDR_W-1:IDX_W]};

  // Byte indices for multi-byte accesses, wrapping modulo the array size
  assign rd_idx1 = idx_n + IDX_W'(1);
  assign rd_idx2 = idx_n + IDX_W'(2);
  assign rd_idx3 = idx_n + IDX_W'(3);
  assign wr_idx1 = idx + IDX_W'(1);
  assign wr_idx2 = idx + IDX_W'(2);
  assign wr_idx3 = idx + IDX_W'(3);

  assign rd_word_c = {mem[rd_idx3], mem[rd_idx2], mem[rd_idx1], mem[idx_n]};

  storage_extend u_extend (
    .word  (rd_word_c),
    .size  (req_n.size),
    .uns   (req_n.uns),
    .ext_c (ext_c)
  );

  // Next-state and request capture; data has fixed priority over fetch
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req;
    idx_n   = idx;
    case (state)
      ST_IDLE: begin
        if (data_en || fetch_read_en) begin
          if (data_en) begin
            req_n.port    = PORT_DATA;
            req_n.size    = data_size;
            req_n.is_load = data_is_load;
            req_n.uns     = data_unsigned;
            req_n.wdata   = data_wdata;
            idx_n         = data_addr[IDX_W-1:0];
          end else begin
            req_n.port    = PORT_FETCH;
            req_n.size    = SZ_WORD;
            req_n.is_load = 1'b1;
            req_n.uns     = 1'b1;
            req_n.wdata   = '0;
            idx_n         = fetch_read_addr[IDX_W-1:0];
          end
          cnt_n   = CNT_W'(MEM_LATENCY - 1);
          state_n = (MEM_LATENCY > 1) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_n = ST_RESP;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Response values registered so they appear exactly in the RESP cycle
  always_comb begin
    fetch_fin_n  = 1'b0;
    data_fin_n   = 1'b0;
    data_err_n   = 1'b0;
    fetch_data_n = '0;
    data_rdata_n = '0;
    busy_n       = (state_n != ST_IDLE);
    if (state_n == ST_RESP) begin
      if (req_n.port == PORT_FETCH) begin
        fetch_fin_n  = 1'b1;
        fetch_data_n = rd_word_c;
      end else begin
        data_fin_n = 1'b1;
        data_err_n = (req_n.size == SZ_ILL);
        if (req_n.is_load) data_rdata_n = ext_c;
      end
    end
  end

  // State, request and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      req             <= '0;
      idx             <= '0;
      fetch_read_fin  <= 1'b0;
      fetch_read_data <= '0;
      data_fin        <= 1'b0;
      data_err        <= 1'b0;
      data_rdata      <= '0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      req             <= req_n;
      idx             <= idx_n;
      fetch_read_fin  <= fetch_fin_n;
      fetch_read_data <= fetch_data_n;
      data_fin        <= data_fin_n;
      data_err        <= data_err_n;
      data_rdata      <= data_rdata_n;
      busy            <= busy_n;
    end
  end

  // Store commit on the edge ending RESP; reset at that edge cancels it
  always_ff @(posedge clk) begin
    if (rst && state == ST_RESP && req.port == PORT_DATA && !req.is_load) begin
      case (req.size)
        SZ_BYTE: mem[idx] <= req.wdata[7:0];
        SZ_HALF: begin
          mem[idx]     <= req.wdata[7:0];
          mem[wr_idx1] <= req.wdata[15:8];
        end
        SZ_WORD: begin
          mem[idx]     <= req.wdata[7:0];
          mem[wr_idx1] <= req.wdata[15:8];
          mem[wr_idx2] <= req.wdata[23:16];
          mem[wr_idx3] <= req.wdata[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_storage_mgmt_responder.sv
// Scoreboard bench: drivers push expected responses from a byte-array model,
// a negedge monitor pops and compares whenever a fin pulse appears.
module tb_storage_mgmt_responder;

  localparam int unsigned MEM_SIZE = 4096;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LAT      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_read_en;
  logic [ADDR_W-1:0] fetch_read_addr;
  logic [31:0]       fetch_read_data;
  logic              fetch_read_fin;
  logic              data_en;
  logic              data_is_load;
  logic [1:0]        data_size;
  logic              data_unsigned;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [31:0]       data_rdata;
  logic              data_fin;
  logic              data_err;
  logic              busy;

  always #5 clk = ~clk;

  storage_mgmt_responder #(
    .MEM_SIZE    (MEM_SIZE),
    .ADDR_W      (ADDR_W),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_read_en   (fetch_read_en),
    .fetch_read_addr (fetch_read_addr),
    .fetch_read_data (fetch_read_data),
    .fetch_read_fin  (fetch_read_fin),
    .data_en         (data_en),
    .data_is_load    (data_is_load),
    .data_size       (data_size),
    .data_unsigned   (data_unsigned),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_rdata      (data_rdata),
    .data_fin        (data_fin),
    .data_err        (data_err),
    .busy            (busy)
  );

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mm [MEM_SIZE];
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Little-endian read of n bytes from the model, wrapping modulo the array size
  function automatic logic [31:0] m_rd(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mm[(a + 32'(i)) % MEM_SIZE]) << (8 * i));
    return v;
  endfunction

  task automatic model_data(input bit ld, input logic [1:0] sz, input bit u,
                            input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   n;
    e.is_data = 1'b1;
    e.err     = 1'b0;
    e.data    = '0;
    if (sz == 2'b11) begin
      e.err = 1'b1;
    end else begin
      n = 1 << sz;
      if (ld) begin
        e.data = m_rd(a, n);
        if (!u && n < 4 && e.data[8*n-1]) e.data = e.data | (32'hffffffff << (8 * n));
      end else begin
        for (int i = 0; i < n; i++) mm[(a + 32'(i)) % MEM_SIZE] = 8'(wd >> (8 * i));
      end
    end
    q.push_back(e);
  endtask

  task automatic model_fetch(input logic [31:0] a);
    exp_t e;
    e.is_data = 1'b0;
    e.err     = 1'b0;
    e.data    = m_rd(a, 4);
    q.push_back(e);
  endtask

  // Monitor: compare every fin against the head of the scoreboard; buses idle otherwise
  always @(negedge clk) begin
    exp_t e;
    if (fetch_read_fin || data_fin) begin
      if (fetch_read_fin && data_fin) begin
        chk("both_fin", 32'd1, 32'd0);
      end else if (q.size() == 0) begin
        chk("unexpected_fin", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("fin_port", 32'(data_fin), 32'(e.is_data));
        chk("fin_data", e.is_data ? data_rdata : fetch_read_data, e.data);
        chk("fin_err", 32'(data_err), 32'(e.err));
        chk("other_bus", e.is_data ? fetch_read_data : data_rdata, 32'd0);
      end
    end else begin
      chk("idle_fdata", fetch_read_data, 32'd0);
      chk("idle_rdata", data_rdata, 32'd0);
      chk("idle_err", 32'(data_err), 32'd0);
    end
  end

  task automatic wait_fin(input bit is_data, input bit was_idle, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (was_idle) chk("busy_during", 32'(busy), 32'd1);
    end while (!(is_data ? data_fin : fetch_read_fin) && n < 64);
    if (!(is_data ? data_fin : fetch_read_fin)) chk("fin_timeout", 32'(n), 32'(LAT));
    else if (was_idle) chk("fin_latency", 32'(n), 32'(LAT));
  endtask

  task automatic run_data(input bit ld, input logic [1:0] sz, input bit u,
                          input logic [31:0] a, input logic [31:0] wd);
    bit was_idle;
    int n;
    model_data(ld, sz, u, a, wd);
    @(negedge clk);
    was_idle      = !busy;
    data_en       = 1'b1;
    data_is_load  = ld;
    data_size     = sz;
    data_unsigned = u;
    data_addr     = a;
    data_wdata    = wd;
    wait_fin(1'b1, was_idle, n);
    data_en = 1'b0;
  endtask

  task automatic run_fetch(input logic [31:0] a);
    bit was_idle;
    int n;
    model_fetch(a);
    @(negedge clk);
    was_idle        = !busy;
    fetch_read_en   = 1'b1;
    fetch_read_addr = a;
    wait_fin(1'b0, was_idle, n);
    fetch_read_en = 1'b0;
  endtask

  // Simultaneous data and fetch: data first, fetch accepted the cycle after data_fin
  task automatic run_both(input bit ld, input logic [1:0] sz, input bit u,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] fa);
    bit was_idle;
    int nd, nf;
    model_data(ld, sz, u, a, wd);
    model_fetch(fa);
    @(negedge clk);
    was_idle        = !busy;
    data_en         = 1'b1;
    data_is_load    = ld;
    data_size       = sz;
    data_unsigned   = u;
    data_addr       = a;
    data_wdata      = wd;
    fetch_read_en   = 1'b1;
    fetch_read_addr = fa;
    wait_fin(1'b1, was_idle, nd);
    data_en = 1'b0;
    wait_fin(1'b0, 1'b0, nf);
    chk("fetch_after_data", 32'(nf), 32'(1 + LAT));
    fetch_read_en = 1'b0;
  endtask

  initial begin
    int          r;
    logic [1:0]  sz;
    rst             = 1'b0;
    fetch_read_en   = 1'b0;
    fetch_read_addr = '0;
    data_en         = 1'b0;
    data_is_load    = 1'b0;
    data_size       = 2'b00;
    data_unsigned   = 1'b0;
    data_addr       = '0;
    data_wdata      = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ffin", 32'(fetch_read_fin), 32'd0);
    chk("rst_dfin", 32'(data_fin), 32'd0);
    rst = 1'b1;

    // Preload the whole array with random words, then the program word at 0
    for (int i = 0; i < int'(MEM_SIZE / 4); i++) run_data(1'b0, 2'b10, 1'b0, 32'(i * 4), $urandom);
    run_data(1'b0, 2'b10, 1'b0, 32'h0, 32'h00a00513);

    run_fetch(32'h0);
    @(negedge clk);
    chk("busy_after_fin", 32'(busy), 32'd0);

    run_both(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h44);
    run_both(1'b0, 2'b10, 1'b0, 32'h0, 32'h12345678, 32'h0);

    // Sign and zero extension of a byte with the top bit set
    run_data(1'b0, 2'b00, 1'b0, 32'h101, 32'h00000080);
    run_data(1'b1, 2'b00, 1'b0, 32'h101, 32'h0);
    run_data(1'b1, 2'b00, 1'b1, 32'h101, 32'h0);
    run_data(1'b1, 2'b01, 1'b0, 32'h101, 32'h0);

    // Wrap at the top of the array
    run_data(1'b0, 2'b01, 1'b0, 32'(MEM_SIZE - 1), 32'h0000beef);
    run_data(1'b1, 2'b00, 1'b1, 32'(MEM_SIZE - 1), 32'h0);
    run_data(1'b1, 2'b00, 1'b1, 32'h0, 32'h0);
    run_data(1'b1, 2'b10, 1'b0, 32'(MEM_SIZE - 1), 32'h0);
    run_fetch(32'(MEM_SIZE - 2));

    // Illegal size: error pulse, no write, zero data
    run_data(1'b0, 2'b11, 1'b0, 32'h8, 32'hffffffff);
    run_data(1'b1, 2'b10, 1'b0, 32'h8, 32'h0);
    run_data(1'b1, 2'b11, 1'b1, 32'h8, 32'h0);

    // Reset during WAIT of a store: abandoned, nothing written
    @(negedge clk);
    data_en      = 1'b1;
    data_is_load = 1'b0;
    data_size    = 2'b00;
    data_addr    = 32'd16;
    data_wdata   = 32'(~mm[16]);
    @(negedge clk);
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst     = 1'b0;
    data_en = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_dfin", 32'(data_fin), 32'd0);
    chk("rst_mid_ffin", 32'(fetch_read_fin), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_data(1'b1, 2'b00, 1'b1, 32'd16, 32'h0);
    run_fetch(32'h0);

    // Randomized mix of fetches, loads, stores and contended pairs
    for (int k = 0; k < 400; k++) begin
      r  = int'($urandom_range(0, 9));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (r < 3)      run_fetch($urandom);
      else if (r < 6) run_data(1'b1, sz, 1'($urandom), $urandom, $urandom);
      else if (r < 9) run_data(1'b0, sz, 1'($urandom), $urandom, $urandom);
      else            run_both(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
